// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and control constants for the pipeline sequencer
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Per-cycle stage control word, MSB first in the order below
    typedef struct packed {
        logic mem_start;
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_exe_en;
        logic id_exe_bubble;
        logic exe_mem_en;
        logic mem_wb_en;
    } ctrl_t;

    // Everything held, nothing launched
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b0000_0000);
    // Freeze plus the one-cycle memory launch pulse
    localparam ctrl_t CTRL_START  = ctrl_t'(8'b1000_0000);
    // Normal advance of every stage
    localparam ctrl_t CTRL_NORM   = ctrl_t'(8'b0110_1011);
    // Hold PC and IF/ID, inject a NOP into ID/EXE, drain the back end
    localparam ctrl_t CTRL_HAZARD = ctrl_t'(8'b0000_1111);
    // Advance everything, squash the two wrong-path instructions
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(8'b0111_1111);

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/memory inputs and stage control outputs of the sequencer
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             mem_start;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_exe_en;
    logic             id_exe_bubble;
    logic             exe_mem_en;
    logic             mem_wb_en_o;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    // Datapath / memory side
    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready,
        input  mem_start, pc_en, if_id_en, if_id_flush, id_exe_en,
               id_exe_bubble, exe_mem_en, mem_wb_en_o, mem_err, stall_cycles
    );

    // Sequencer side
    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready,
        output mem_start, pc_en, if_id_en, if_id_flush, id_exe_en,
               id_exe_bubble, exe_mem_en, mem_wb_en_o, mem_err, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - RAW hazard detection for the ID-stage instruction
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_use_src2_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_read_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_wb_en_i,
    output logic             hazard_o
);

    logic s1_exe, s2_exe, s1_mem, s2_mem;

    // A source only matches when the instruction actually reads it
    always_comb begin
        s1_exe = id_use_src1_i & exe_wb_en_i & (id_src1_i == exe_dest_i);
        s2_exe = id_use_src2_i & exe_wb_en_i & (id_src2_i == exe_dest_i);
        s1_mem = id_use_src1_i & mem_wb_en_i & (id_src1_i == mem_dest_i);
        s2_mem = id_use_src2_i & mem_wb_en_i & (id_src2_i == mem_dest_i);
    end

    // With forwarding only a load in EXE cannot supply its result in time
    always_comb begin
        if (FWD_EN)
            hazard_o = exe_mem_read_i & (s1_exe | s2_exe);
        else
            hazard_o = s1_exe | s2_exe | s1_mem | s2_mem;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline register sequencer: stalls, flushes, memory freeze
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '1;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    logic [CNT_W-1:0]  stall_q;
    logic              hazard;
    ctrl_t             run_ctrl;
    ctrl_t             ctrl;

    hazard_detect #(.FWD_EN(FWD_EN)) u_hazard (
        .id_src1_i      (bus.id_src1),
        .id_src2_i      (bus.id_src2),
        .id_use_src1_i  (bus.id_use_src1),
        .id_use_src2_i  (bus.id_use_src2),
        .exe_dest_i     (bus.exe_dest),
        .exe_wb_en_i    (bus.exe_wb_en),
        .exe_mem_read_i (bus.exe_mem_read),
        .mem_dest_i     (bus.mem_dest),
        .mem_wb_en_i    (bus.mem_wb_en),
        .hazard_o       (hazard)
    );

    // Branch beats hazard beats normal flow; used in RUN and on memory release
    always_comb begin
        if (bus.branch_taken)
            run_ctrl = CTRL_BRANCH;
        else if (hazard)
            run_ctrl = CTRL_HAZARD;
        else
            run_ctrl = CTRL_NORM;
    end

    // Stage controls: memory freeze beats everything, all zero while in reset
    always_comb begin
        ctrl = CTRL_FREEZE;
        if (!rst) begin
            case (state_q)
                RUN:      ctrl = bus.mem_req ? CTRL_START : run_ctrl;
                MEM_WAIT: ctrl = bus.mem_ready ? run_ctrl : CTRL_FREEZE;
                default:  ctrl = CTRL_FREEZE;
            endcase
        end
    end

    // FSM, memory wait counter, sticky timeout and freeze-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            if (!ctrl.pc_en)
                stall_q <= stall_q + CNT_W'(1);
            case (state_q)
                RUN: begin
                    if (bus.mem_req) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (TIMEOUT_EN && wait_q == WAIT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.mem_start     = ctrl.mem_start;
    assign bus.pc_en         = ctrl.pc_en;
    assign bus.if_id_en      = ctrl.if_id_en;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_exe_en     = ctrl.id_exe_en;
    assign bus.id_exe_bubble = ctrl.id_exe_bubble;
    assign bus.exe_mem_en    = ctrl.exe_mem_en;
    assign bus.mem_wb_en_o   = ctrl.mem_wb_en;
    assign bus.mem_err       = err_q;
    assign bus.stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(32)) ifa ();
    pipe_ctrl_if #(.CNT_W(32)) ifb ();

    // a: forwarding, short timeout; b: no forwarding, timeout disabled
    pipe_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(0), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // {mem_start, pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en, mem_wb_en_o}
    localparam logic [7:0] E_FRZ = 8'b0000_0000;
    localparam logic [7:0] E_STA = 8'b1000_0000;
    localparam logic [7:0] E_NRM = 8'b0110_1011;
    localparam logic [7:0] E_HAZ = 8'b0000_1111;
    localparam logic [7:0] E_BRA = 8'b0111_1111;

    typedef struct {
        string      tag;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } sb_t;

    sb_t         sb[$];
    int          n_asserts = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall_a = 0;
    logic [31:0] exp_stall_b = 0;
    logic        exp_err_a = 0;
    logic        exp_err_b = 0;
    logic [7:0]  outs_a, outs_b;

    assign outs_a = {ifa.mem_start, ifa.pc_en, ifa.if_id_en, ifa.if_id_flush,
                     ifa.id_exe_en, ifa.id_exe_bubble, ifa.exe_mem_en, ifa.mem_wb_en_o};
    assign outs_b = {ifb.mem_start, ifb.pc_en, ifb.if_id_en, ifb.if_id_flush,
                     ifb.id_exe_en, ifb.id_exe_bubble, ifb.exe_mem_en, ifb.mem_wb_en_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] s1, input logic [3:0] s2, input logic u1, input logic u2,
                          input logic [3:0] ed, input logic ewb, input logic erd,
                          input logic [3:0] md, input logic mwb,
                          input logic br, input logic mreq, input logic mrdy);
        ifa.id_src1 = s1;  ifb.id_src1 = s1;
        ifa.id_src2 = s2;  ifb.id_src2 = s2;
        ifa.id_use_src1 = u1;  ifb.id_use_src1 = u1;
        ifa.id_use_src2 = u2;  ifb.id_use_src2 = u2;
        ifa.exe_dest = ed;  ifb.exe_dest = ed;
        ifa.exe_wb_en = ewb;  ifb.exe_wb_en = ewb;
        ifa.exe_mem_read = erd;  ifb.exe_mem_read = erd;
        ifa.mem_dest = md;  ifb.mem_dest = md;
        ifa.mem_wb_en = mwb;  ifb.mem_wb_en = mwb;
        ifa.branch_taken = br;  ifb.branch_taken = br;
        ifa.mem_req = mreq;  ifb.mem_req = mreq;
        ifa.mem_ready = mrdy;  ifb.mem_ready = mrdy;
    endtask

    // Push expectation, compare mid-cycle, advance one clock and check counters
    task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        sb_t e;
        sb.push_back('{tag: tag, exp_a: ea, exp_b: eb});
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, "/ctrl_a"}, {24'd0, outs_a}, {24'd0, e.exp_a});
        check({e.tag, "/ctrl_b"}, {24'd0, outs_b}, {24'd0, e.exp_b});
        @(posedge clk);
        #1;
        if (!ea[6]) exp_stall_a++;
        if (!eb[6]) exp_stall_b++;
        check({tag, "/stall_a"}, ifa.stall_cycles, exp_stall_a);
        check({tag, "/stall_b"}, ifb.stall_cycles, exp_stall_b);
        check({tag, "/err_a"}, {31'd0, ifa.mem_err}, {31'd0, exp_err_a});
        check({tag, "/err_b"}, {31'd0, ifb.mem_err}, {31'd0, exp_err_b});
    endtask

    initial begin
        // Reset with active inputs: everything must stay forced low
        rst = 1'b1;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("reset/ctrl_a", {24'd0, outs_a}, 32'd0);
        check("reset/ctrl_b", {24'd0, outs_b}, 32'd0);
        check("reset/stall_a", ifa.stall_cycles, 32'd0);
        check("reset/err_a", {31'd0, ifa.mem_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle", E_NRM, E_NRM);

        // Load-use on src1: both configurations stall one cycle
        set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("load_use", E_HAZ, E_HAZ);
        set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_moved", E_NRM, E_HAZ);

        // MEM-stage RAW on src2: only the non-forwarding pipe stalls
        set_in(4'd0, 4'd5, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mem_raw", E_NRM, E_HAZ);
        set_in(4'd0, 4'd5, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mem_raw_unused", E_NRM, E_NRM);
        set_in(4'd7, 4'd5, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("exe_raw_alu", E_NRM, E_HAZ);

        // Branch and load-use together: branch wins
        set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("branch_hazard", E_BRA, E_BRA);

        // Memory access with a branch held across the freeze
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mem_launch", E_STA, E_STA);
        step("mem_wait1", E_FRZ, E_FRZ);
        step("mem_wait2", E_FRZ, E_FRZ);
        step("mem_wait3", E_FRZ, E_FRZ);
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("mem_release_branch", E_BRA, E_BRA);
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("after_release", E_NRM, E_NRM);

        // Timeout: ready never comes; err sets on the fourth wait cycle of dut_a only
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("to_launch", E_STA, E_STA);
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("to_wait1", E_FRZ, E_FRZ);
        step("to_wait2", E_FRZ, E_FRZ);
        step("to_wait3", E_FRZ, E_FRZ);
        exp_err_a = 1'b1;
        step("to_wait4", E_FRZ, E_FRZ);
        step("to_wait5", E_FRZ, E_FRZ);
        step("to_wait6", E_FRZ, E_FRZ);

        // Reset while waiting: outputs forced low at once, counters and error cleared
        rst = 1'b1;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("rst_wait/ctrl_a", {24'd0, outs_a}, 32'd0);
        check("rst_wait/ctrl_b", {24'd0, outs_b}, 32'd0);
        check("rst_wait/err_a", {31'd0, ifa.mem_err}, 32'd0);
        check("rst_wait/stall_a", ifa.stall_cycles, 32'd0);
        check("rst_wait/stall_b", ifb.stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err_a = 1'b0;
        exp_stall_a = 0;
        exp_stall_b = 0;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_rst_run", E_NRM, E_NRM);
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("post_rst_launch", E_STA, E_STA);
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("post_rst_min_access", E_NRM, E_NRM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
